mult_req_scheduler: RTL and testbench

- Sequences the shared 8x8 multiplier between the two serial front ends, UART and SPI.
- Collects an operand pair (A then B) from each requester's RX byte stream and arbitrates round-robin for one shared shift-add multiply engine.
- Returns the 16-bit product, high byte first, on the TX path of the requester that sent the operands.
- Sits between the UART/SPI RX/TX cores and the top-level pin wrapper.

---
 rtl/mult_req_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_mult_req_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_req_scheduler.sv
// Shares one 8x8 shift-add multiplier between the UART and SPI front ends.
// Each side collects an A/B operand pair; a round-robin arbiter hands the engine out and the product returns high byte first.
module mult_req_scheduler #(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_valid,
    input  logic [7:0] spi_rx_data,
    input  logic       spi_rx_valid,
    input  logic       uart_tx_ready,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_start,
    input  logic       spi_tx_done,
    output logic [7:0] spi_tx_data,
    output logic       spi_tx_load,
    input  logic       err_clr,
    output logic       busy,
    output logic [1:0] grant,
    output logic [3:0] err
);
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [1:0] C_EMPTY  = 2'd0;
    localparam logic [1:0] C_HAVE_A = 2'd1;
    localparam logic [1:0] C_PAIR   = 2'd2;

    localparam logic [2:0] E_IDLE    = 3'd0;
    localparam logic [2:0] E_MUL     = 3'd1;
    localparam logic [2:0] E_SEND_HI = 3'd2;
    localparam logic [2:0] E_WAIT_HI = 3'd3;
    localparam logic [2:0] E_SEND_LO = 3'd4;
    localparam logic [2:0] E_WAIT_LO = 3'd5;

    // Index 0 is the UART requester, index 1 the SPI requester.
    logic [1:0]         rx_valid;
    logic [1:0][7:0]    rx_data;
    logic [1:0][1:0]    col_state_q, col_state_d;
    logic [1:0][7:0]    op_a_q, op_a_d;
    logic [1:0][7:0]    op_b_q, op_b_d;
    logic [1:0][CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]         err_set;
    logic [3:0]         err_q, err_d;

    logic [2:0]  eng_state_q, eng_state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  grant_new;
    logic [1:0]  pair_ready;
    logic        prefer_spi_q, prefer_spi_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  mul_cnt_q, mul_cnt_d;
    logic        seen_low_q, seen_low_d;
    logic [7:0]  uart_tx_data_q, uart_tx_data_d;
    logic [7:0]  spi_tx_data_q, spi_tx_data_d;
    logic        wait_done;

    assign rx_valid = {spi_rx_valid, uart_rx_valid};
    assign rx_data  = {spi_rx_data, uart_rx_data};

    always_comb begin
        pair_ready[0] = (col_state_q[0] == C_PAIR);
        pair_ready[1] = (col_state_q[1] == C_PAIR);
        grant_new = 2'b00;
        if (eng_state_q == E_IDLE) begin
            if (pair_ready == 2'b11) grant_new = prefer_spi_q ? 2'b10 : 2'b01;
            else                     grant_new = pair_ready;
        end
    end

    // Collectors; a byte arriving on the grant edge starts the next pair.
    always_comb begin
        col_state_d = col_state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_set     = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            case (col_state_q[i])
                C_EMPTY: begin
                    if (rx_valid[i]) begin
                        op_a_d[i]      = rx_data[i];
                        tmo_cnt_d[i]   = '0;
                        col_state_d[i] = C_HAVE_A;
                    end
                end
                C_HAVE_A: begin
                    if (rx_valid[i]) begin
                        op_b_d[i]      = rx_data[i];
                        col_state_d[i] = C_PAIR;
                    end else if (tmo_cnt_q[i] == CW'(TIMEOUT - 1)) begin
                        col_state_d[i]    = C_EMPTY;
                        err_set[2*i + 1]  = 1'b1;
                    end else begin
                        tmo_cnt_d[i] = tmo_cnt_q[i] + CW'(1);
                    end
                end
                C_PAIR: begin
                    if (grant_new[i]) begin
                        if (rx_valid[i]) begin
                            op_a_d[i]      = rx_data[i];
                            tmo_cnt_d[i]   = '0;
                            col_state_d[i] = C_HAVE_A;
                        end else begin
                            col_state_d[i] = C_EMPTY;
                        end
                    end else if (rx_valid[i]) begin
                        err_set[2*i] = 1'b1;
                    end
                end
                default: col_state_d[i] = C_EMPTY;
            endcase
        end
        err_d = err_clr ? err_set : (err_q | err_set);
    end

    always_comb begin
        eng_state_d    = eng_state_q;
        grant_d        = grant_q;
        prefer_spi_d   = prefer_spi_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        acc_d          = acc_q;
        mul_cnt_d      = mul_cnt_q;
        seen_low_d     = seen_low_q;
        uart_tx_data_d = uart_tx_data_q;
        spi_tx_data_d  = spi_tx_data_q;
        uart_tx_start  = 1'b0;
        spi_tx_load    = 1'b0;
        wait_done      = grant_q[0] ? (seen_low_q && uart_tx_ready) : spi_tx_done;
        case (eng_state_q)
            E_IDLE: begin
                if (grant_new != 2'b00) begin
                    grant_d      = grant_new;
                    prefer_spi_d = grant_new[0];
                    mcand_d      = {8'h00, grant_new[1] ? op_a_q[1] : op_a_q[0]};
                    mplier_d     = grant_new[1] ? op_b_q[1] : op_b_q[0];
                    acc_d        = 16'h0000;
                    mul_cnt_d    = 3'd0;
                    eng_state_d  = E_MUL;
                end
            end
            E_MUL: begin
                acc_d     = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
                mcand_d   = {mcand_q[14:0], 1'b0};
                mplier_d  = {1'b0, mplier_q[7:1]};
                mul_cnt_d = mul_cnt_q + 3'd1;
                if (mul_cnt_q == 3'd7) begin
                    if (grant_q[0]) uart_tx_data_d = acc_d[15:8];
                    else            spi_tx_data_d  = acc_d[15:8];
                    eng_state_d = E_SEND_HI;
                end
            end
            E_SEND_HI, E_SEND_LO: begin
                if (grant_q[0]) begin
                    if (uart_tx_ready) begin
                        uart_tx_start = 1'b1;
                        seen_low_d    = 1'b0;
                        eng_state_d   = (eng_state_q == E_SEND_HI) ? E_WAIT_HI : E_WAIT_LO;
                    end
                end else begin
                    spi_tx_load = 1'b1;
                    eng_state_d = (eng_state_q == E_SEND_HI) ? E_WAIT_HI : E_WAIT_LO;
                end
            end
            E_WAIT_HI, E_WAIT_LO: begin
                if (grant_q[0] && !uart_tx_ready) seen_low_d = 1'b1;
                if (wait_done) begin
                    if (eng_state_q == E_WAIT_HI) begin
                        if (grant_q[0]) uart_tx_data_d = acc_q[7:0];
                        else            spi_tx_data_d  = acc_q[7:0];
                        eng_state_d = E_SEND_LO;
                    end else begin
                        grant_d     = 2'b00;
                        eng_state_d = E_IDLE;
                    end
                end
            end
            default: begin
                grant_d     = 2'b00;
                eng_state_d = E_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_state_q    <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            tmo_cnt_q      <= '0;
            err_q          <= 4'b0000;
            eng_state_q    <= E_IDLE;
            grant_q        <= 2'b00;
            prefer_spi_q   <= 1'b0;
            mcand_q        <= 16'h0000;
            mplier_q       <= 8'h00;
            acc_q          <= 16'h0000;
            mul_cnt_q      <= 3'd0;
            seen_low_q     <= 1'b0;
            uart_tx_data_q <= 8'h00;
            spi_tx_data_q  <= 8'h00;
        end else begin
            col_state_q    <= col_state_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            tmo_cnt_q      <= tmo_cnt_d;
            err_q          <= err_d;
            eng_state_q    <= eng_state_d;
            grant_q        <= grant_d;
            prefer_spi_q   <= prefer_spi_d;
            mcand_q        <= mcand_d;
            mplier_q       <= mplier_d;
            acc_q          <= acc_d;
            mul_cnt_q      <= mul_cnt_d;
            seen_low_q     <= seen_low_d;
            uart_tx_data_q <= uart_tx_data_d;
            spi_tx_data_q  <= spi_tx_data_d;
        end
    end

    assign uart_tx_data = uart_tx_data_q;
    assign spi_tx_data  = spi_tx_data_q;
    assign busy         = (eng_state_q != E_IDLE);
    assign grant        = grant_q;
    assign err          = err_q;
endmodule

// File: tb/tb_mult_req_scheduler.sv
// Directed bench for mult_req_scheduler: a scoreboard queue of {port, grant, byte} is
// filled as operand pairs are driven and drained whenever a TX pulse appears.
module tb_mult_req_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic [7:0] spi_rx_data;
    logic       spi_rx_valid;
    logic       uart_tx_ready;
    logic [7:0] uart_tx_data;
    logic       uart_tx_start;
    logic       spi_tx_done;
    logic [7:0] spi_tx_data;
    logic       spi_tx_load;
    logic       err_clr;
    logic       busy;
    logic [1:0] grant;
    logic [3:0] err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int b_cyc    = 0;
    logic lat_armed = 1'b0;

    logic [11:0] exp_q[$];
    logic [11:0] mon_obs;
    logic [11:0] mon_exp;

    logic uart_started  = 1'b0;
    logic spi_load_seen = 1'b0;
    int   uart_busy_cnt = 0;
    int   spi_done_cnt  = 0;

    mult_req_scheduler #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .uart_tx_ready(uart_tx_ready), .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
        .spi_tx_done(spi_tx_done), .spi_tx_data(spi_tx_data), .spi_tx_load(spi_tx_load),
        .err_clr(err_clr), .busy(busy), .grant(grant), .err(err)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic uart_byte(input logic [7:0] d);
        uart_rx_data  = d;
        uart_rx_valid = 1'b1;
        b_cyc         = cyc;
        tick();
        uart_rx_valid = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] d);
        spi_rx_data  = d;
        spi_rx_valid = 1'b1;
        b_cyc        = cyc;
        tick();
        spi_rx_valid = 1'b0;
    endtask

    task automatic both_bytes(input logic [7:0] du, input logic [7:0] ds);
        uart_rx_data  = du;
        spi_rx_data   = ds;
        uart_rx_valid = 1'b1;
        spi_rx_valid  = 1'b1;
        b_cyc         = cyc;
        tick();
        uart_rx_valid = 1'b0;
        spi_rx_valid  = 1'b0;
    endtask

    // Expected product bytes, high first, tagged with the port that must send them.
    task automatic push_job(input logic [1:0] port, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = {8'h00, a} * {8'h00, b};
        exp_q.push_back({port, port, p[15:8]});
        exp_q.push_back({port, port, p[7:0]});
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        check("wait_done_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic check_reset_outs(input string tag);
        check(tag, {uart_tx_data, spi_tx_data, uart_tx_start, spi_tx_load, busy, grant, err}, 32'd0);
    endtask

    // Monitor: compare every TX pulse against the scoreboard head
    always @(negedge clk) begin
        if (uart_tx_start || spi_tx_load) begin
            mon_obs = {spi_tx_load, uart_tx_start, grant, uart_tx_start ? uart_tx_data : spi_tx_data};
            if (exp_q.size() == 0) begin
                check("tx_pulse_unexpected", {20'd0, mon_obs}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_byte", {20'd0, mon_obs}, {20'd0, mon_exp});
            end
            if (lat_armed) begin
                lat_armed = 1'b0;
                check("first_tx_latency", cyc - b_cyc, 32'd10);
            end
            if (uart_tx_start) uart_started = 1'b1;
            if (spi_tx_load) spi_load_seen = 1'b1;
        end
    end

    // TX side models: UART busy for 20 cycles after start, SPI done 5 cycles after load
    always begin
        @(posedge clk);
        #1;
        if (uart_started) begin
            uart_started  = 1'b0;
            uart_tx_ready = 1'b0;
            uart_busy_cnt = 20;
        end else if (uart_busy_cnt > 0) begin
            uart_busy_cnt--;
            if (uart_busy_cnt == 0) uart_tx_ready = 1'b1;
        end
        spi_tx_done = 1'b0;
        if (spi_done_cnt > 0) begin
            spi_done_cnt--;
            if (spi_done_cnt == 0) spi_tx_done = 1'b1;
        end
        if (spi_load_seen) begin
            spi_load_seen = 1'b0;
            spi_done_cnt  = 4;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        reset         = 1'b1;
        uart_rx_data  = 8'h00;
        uart_rx_valid = 1'b0;
        spi_rx_data   = 8'h00;
        spi_rx_valid  = 1'b0;
        uart_tx_ready = 1'b1;
        spi_tx_done   = 1'b0;
        err_clr       = 1'b0;
        repeat (3) tick();
        check_reset_outs("reset_outputs");
        reset = 1'b0;
        tick();

        // UART pair 0x0C * 0x0D
        push_job(2'b01, 8'h0C, 8'h0D);
        uart_byte(8'h0C);
        lat_armed = 1'b1;
        uart_byte(8'h0D);
        tick();
        check("uart_grant", {30'd0, grant}, 32'h1);
        check("uart_busy", {31'd0, busy}, 32'h1);
        wait_done(300);
        check("uart_grant_cleared", {30'd0, grant}, 32'h0);
        check("uart_err", {28'd0, err}, 32'h0);
        check("uart_latency_seen", {31'd0, lat_armed}, 32'h0);

        // SPI pair 0xFF * 0xFF
        push_job(2'b10, 8'hFF, 8'hFF);
        spi_byte(8'hFF);
        lat_armed = 1'b1;
        spi_byte(8'hFF);
        tick();
        check("spi_grant", {30'd0, grant}, 32'h2);
        wait_done(300);
        check("spi_err", {28'd0, err}, 32'h0);

        // Simultaneous pairs, pointer favours UART
        push_job(2'b01, 8'h03, 8'h05);
        push_job(2'b10, 8'h10, 8'h10);
        both_bytes(8'h03, 8'h10);
        both_bytes(8'h05, 8'h10);
        tick();
        check("simul1_grant", {30'd0, grant}, 32'h1);
        wait_done(400);

        // SPI overrun while UART owns the engine
        push_job(2'b01, 8'h11, 8'h22);
        push_job(2'b10, 8'h07, 8'h09);
        uart_byte(8'h11);
        uart_byte(8'h22);
        tick();
        check("ovr_uart_grant", {30'd0, grant}, 32'h1);
        spi_byte(8'h07);
        spi_byte(8'h09);
        spi_byte(8'h33);
        check("ovr_err_set", {28'd0, err}, 32'h4);
        wait_done(400);
        check("ovr_err_sticky", {28'd0, err}, 32'h4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovr_err_cleared", {28'd0, err}, 32'h0);

        // B arriving on the timeout-match cycle still completes the pair
        push_job(2'b01, 8'h05, 8'h07);
        uart_byte(8'h05);
        repeat (15) tick();
        uart_byte(8'h07);
        wait_done(300);
        check("tmo_edge_err", {28'd0, err}, 32'h0);

        // UART holds only A: discarded after 16 cycles
        uart_byte(8'hAA);
        repeat (15) tick();
        check("tmo_not_yet", {28'd0, err}, 32'h0);
        tick();
        check("tmo_err_set", {28'd0, err}, 32'h2);
        push_job(2'b01, 8'h02, 8'h03);
        uart_byte(8'h02);
        uart_byte(8'h03);
        wait_done(300);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("tmo_err_cleared", {28'd0, err}, 32'h0);

        // Simultaneous again, last grant was UART so SPI goes first
        push_job(2'b10, 8'h0A, 8'h0B);
        push_job(2'b01, 8'h21, 8'h02);
        both_bytes(8'h21, 8'h0A);
        both_bytes(8'h02, 8'h0B);
        tick();
        check("simul2_grant", {30'd0, grant}, 32'h2);
        wait_done(400);

        // Reset during MUL cycle 4 drops the job
        uart_byte(8'hFF);
        uart_byte(8'h02);
        repeat (4) tick();
        check("pre_reset_busy", {31'd0, busy}, 32'h1);
        reset = 1'b1;
        #1;
        check_reset_outs("mid_reset_outputs");
        repeat (2) tick();
        reset = 1'b0;
        repeat (40) tick();
        check("post_reset_idle", {29'd0, busy, grant}, 32'h0);

        push_job(2'b01, 8'h04, 8'h05);
        uart_byte(8'h04);
        uart_byte(8'h05);
        wait_done(300);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
